// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC register, combinational imem access and a
// 2-entry {pc, instr} buffer toward decode, with redirect and misalignment halt.
module instruction_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            misaligned,
  output logic [XLEN-1:0] fault_pc
);

  // state  | meaning
  // S_RUN  | fetching sequentially into the buffer
  // S_HALT | stopped on a misaligned redirect target, buffer kept empty
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fault_pc;
  logic [XLEN-1:0] r_ent_pc    [0:1];
  logic [31:0]     r_ent_instr [0:1];
  logic            r_head;
  logic [1:0]      r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_tail;
  logic            w_target_misaligned;

  assign w_full              = (r_count == 2'd2);
  assign w_empty             = (r_count == 2'd0);
  assign w_target_misaligned = (redirect_pc[1:0] != 2'b00);
  // Free slot is head^1 with one entry; with two entries it is only written
  // when a pop frees the head slot on the same edge.
  assign w_tail              = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = w_target_misaligned ? S_HALT : S_RUN;
    end
  end

  always_comb begin
    w_pop      = !w_empty && out_ready && !redirect_valid;
    w_push     = 1'b0;
    misaligned = 1'b0;
    case (r_state)
      S_RUN:   w_push = !redirect_valid && (!w_full || w_pop);
      S_HALT:  misaligned = 1'b1;
      default: w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_head  <= 1'b0;
      r_count <= 2'd0;
      if (w_target_misaligned) begin
        r_fault_pc <= redirect_pc;
      end
    end else begin
      if (w_push) begin
        r_pc <= r_pc + XLEN'(4);
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset: it is only observable through r_count.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_ent_pc[w_tail]    <= r_pc;
      r_ent_instr[w_tail] <= imem_instr;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = r_ent_pc[r_head];
  assign out_instr = r_ent_instr[r_head];
  assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table, a scoreboard drain
// sequence and a PC wrap check on a second instance.
module tb_instruction_fetch;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            misaligned;
  logic [XLEN-1:0] fault_pc;

  logic [XLEN-1:0] w_imem_addr;
  logic [31:0]     w_imem_instr;
  logic            w_redirect_valid = 1'b0;
  logic [XLEN-1:0] w_redirect_pc = '0;
  logic            w_out_valid;
  logic            w_out_ready = 1'b1;
  logic [XLEN-1:0] w_out_pc;
  logic [31:0]     w_out_instr;
  logic            w_misaligned;
  logic [XLEN-1:0] w_fault_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h5A3C_0F00 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_instr   = word_of(imem_addr);
  assign w_imem_instr = word_of(w_imem_addr);

  instruction_fetch #(.XLEN(XLEN), .RESET_PC('0)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misaligned(misaligned), .fault_pc(fault_pc)
  );

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .out_instr(w_out_instr), .misaligned(w_misaligned), .fault_pc(w_fault_pc)
  );

  typedef struct {
    logic            rst;
    logic            rdy;
    logic            rv;
    logic [XLEN-1:0] rpc;
    logic            e_valid;
    logic [XLEN-1:0] e_pc;
    logic [XLEN-1:0] e_addr;
    logic            e_mis;
    logic [XLEN-1:0] e_fault;
  } vec_t;

  vec_t vecs[$];
  logic [XLEN-1:0] sb[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [XLEN-1:0] rpc, input logic e_valid,
                              input logic [XLEN-1:0] e_pc, input logic [XLEN-1:0] e_addr,
                              input logic e_mis, input logic [XLEN-1:0] e_fault);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_addr = e_addr; v.e_mis = e_mis; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [XLEN-1:0] rpc);
    reset = rst;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // rst rdy rv rpc | valid pc addr mis fault
    vecs.push_back(mk(1, 0, 0, 0,       0, 0,      0,      0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,      0,      0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 0,      4,      0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 4,      8,      0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 8,      12,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 12,     16,     0, 0));
    vecs.push_back(mk(1, 0, 0, 0,       0, 0,      0,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0,      4,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0,      8,      0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 4,      12,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 8,      16,     0, 0));
    vecs.push_back(mk(0, 0, 1, 'h100,   0, 0,      'h100,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 'h100,  'h104,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 'h104,  'h108,  0, 0));
    vecs.push_back(mk(0, 1, 1, 'h102,   0, 0,      'h102,  1, 'h102));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h102, 1, 'h102));
    vecs.push_back(mk(0, 1, 1, 'h200,   0, 0,      'h200,  0, 'h102));
    vecs.push_back(mk(0, 1, 0, 0,       1, 'h200,  'h204,  0, 'h102));
    vecs.push_back(mk(0, 0, 0, 0,       1, 'h200,  'h208,  0, 'h102));
    vecs.push_back(mk(0, 0, 0, 0,       1, 'h200,  'h208,  0, 'h102));
    vecs.push_back(mk(1, 0, 1, 'h302,   0, 0,      0,      0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       1, 0,      4,      0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      chk($sformatf("row%0d valid", i), XLEN'(out_valid), XLEN'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("row%0d instr", i), XLEN'(out_instr), XLEN'(word_of(vecs[i].e_pc)));
      end
      chk($sformatf("row%0d addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d mis", i), XLEN'(misaligned), XLEN'(vecs[i].e_mis));
      chk($sformatf("row%0d fault", i), fault_pc, vecs[i].e_fault);
    end

    // Stall then drain through the scoreboard: no loss, no duplication.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall addr", imem_addr, 8);
    for (int i = 0; i < 5; i++) sb.push_back(XLEN'(4 * i));
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
      if (out_valid) begin
        logic [XLEN-1:0] e;
        e = sb.pop_front();
        chk("drain pc", out_pc, e);
        chk("drain instr", XLEN'(out_instr), XLEN'(word_of(e)));
      end
      step(0, 1, 0, 0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: %0d entries left expected 0", sb.size());
    end

    // PC wraps modulo 2^XLEN on the second instance.
    step(1, 1, 0, 0);
    chk("wrap reset valid", XLEN'(w_out_valid), 0);
    step(0, 1, 0, 0);
    chk("wrap first valid", XLEN'(w_out_valid), 1);
    chk("wrap first pc", w_out_pc, WRAP_PC);
    step(0, 1, 0, 0);
    chk("wrap second valid", XLEN'(w_out_valid), 1);
    chk("wrap second pc", w_out_pc, 0);
    chk("wrap second instr", XLEN'(w_out_instr), XLEN'(word_of(0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the address and PC width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_addr, output, width XLEN: byte address to instruction memory.
REQ-006 The block SHALL have port imem_instr, input, width 32: instruction word returned combinationally for imem_addr.
REQ-007 The block SHALL have port redirect_valid, input, width 1: branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, width XLEN: redirect target address.
REQ-009 The block SHALL have port out_valid, output, width 1: head of fetch buffer is valid.
REQ-010 The block SHALL have port out_ready, input, width 1: decode accepts head this cycle.
REQ-011 The block SHALL have port out_pc, output, width XLEN: PC of head entry.
REQ-012 The block SHALL have port out_instr, output, width 32: instruction of head entry.
REQ-013 The block SHALL have port misaligned, output, width 1: fetch halted on misaligned target.
REQ-014 The block SHALL have port fault_pc, output, width XLEN: offending redirect target, valid while misaligned=1.

Function
REQ-015 The block SHALL hold a PC register pc_q and drive imem_addr = pc_q combinationally.
REQ-016 The block SHALL contain a 2-entry FIFO of {pc, instr}; out_valid = FIFO not empty; out_pc/out_instr = head entry.
REQ-017 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-018 FSM states SHALL be RUN and HALT only.
REQ-019 In RUN with redirect_valid=0, a push of {pc_q, imem_instr} SHALL occur when FIFO not full, or full with pop the same cycle; on push pc_q <= pc_q + 4, wrapping modulo 2^XLEN.
REQ-020 When no push occurs, pc_q SHALL hold.
REQ-021 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-022 redirect_valid=1 SHALL take priority over everything in either state: FIFO cleared, no push, no pop counted, pc_q <= redirect_pc, on the same edge.
REQ-023 After a redirect, out_valid SHALL be 0 in the next cycle; the first entry from the target SHALL appear with out_valid=1 one cycle later (2-cycle redirect-to-valid latency).
REQ-024 A redirect with redirect_pc[1:0] != 0 SHALL move the FSM to HALT, set misaligned=1 and fault_pc=redirect_pc.
REQ-025 A redirect with redirect_pc[1:0] == 0 SHALL move the FSM to RUN and clear misaligned.
REQ-026 In HALT the block SHALL perform no push, keep the FIFO empty, and hold pc_q and fault_pc.
REQ-027 HALT SHALL be left only by an aligned redirect or reset.
REQ-028 While misaligned=0, fault_pc SHALL hold its last value.
REQ-029 A full FIFO with out_ready=0 SHALL stall pc_q and retain both entries unchanged indefinitely.

Reset
REQ-030 reset=1 SHALL override redirect_valid and set pc_q=RESET_PC, FIFO empty, FSM=RUN, misaligned=0, fault_pc=0.
REQ-031 During reset out_valid SHALL be 0; reset asserted mid-operation SHALL discard all buffered entries on that edge.
REQ-032 The first push SHALL occur on the first edge with reset=0, giving out_valid=1, out_pc=RESET_PC one cycle after reset deasserts.

Verification
REQ-033 Reset then out_ready=1, imem returns addr-derived words -> out_pc sequence 0,4,8,12 on consecutive cycles, out_valid held 1.
REQ-034 out_ready=0 for 5 cycles after reset -> FIFO holds pc 0 and 4, imem_addr stuck at 8; ready=1 -> pops 0,4,8 in order, no loss or duplication.
REQ-035 redirect_valid=1, redirect_pc=0x100 with 2 entries buffered -> out_valid=0 next cycle, then out_pc=0x100, then 0x104.
REQ-036 redirect_pc=0x102 -> misaligned=1, fault_pc=0x102, out_valid stays 0 for 10 cycles; then redirect_pc=0x200 -> misaligned=0, out_pc=0x200 two cycles later.
REQ-037 RESET_PC=2^XLEN-4, ready=1 -> out_pc sequence 0xFFFF_FFFF_FFFF_FFFC then 0x0.
REQ-038 reset and redirect_valid asserted together with FIFO full -> next cycle pc_q=RESET_PC, FIFO empty, misaligned=0.
